// File: rtl/rtype_exec_sequencer_pkg.sv
// Shared constants for the R-type execute sequencer: funct codes, ALU opcodes,
// FSM state encoding and instruction field positions.
package rtype_exec_sequencer_pkg;

   localparam logic [5:0] FUNCT_SLL = 6'h00;
   localparam logic [5:0] FUNCT_SRL = 6'h02;
   localparam logic [5:0] FUNCT_SRA = 6'h03;
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SRL = 4'b1101;
   localparam logic [3:0] ALU_SLL = 4'b1110;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WB,
      ST_FAULT
   } state_t;

   localparam int OPC_MSB   = 31;
   localparam int OPC_LSB   = 26;
   localparam int RS_MSB    = 25;
   localparam int RS_LSB    = 21;
   localparam int RT_MSB    = 20;
   localparam int RT_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 11;
   localparam int SHAMT_MSB = 10;
   localparam int SHAMT_LSB = 6;
   localparam int FUNCT_MSB = 5;
   localparam int FUNCT_LSB = 0;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational R-type decode: opcode/funct to ALU opcode, legality and
// operand-routing flags for the shift instructions.
module rtype_decoder
   import rtype_exec_sequencer_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       legal,
   output logic       swap_rt_to_a,
   output logic       is_shift
);

   always_comb begin
      alu_op       = ALU_AND;
      legal        = (opcode == 6'd0);
      swap_rt_to_a = 1'b0;
      is_shift     = 1'b0;
      case (funct)
         FUNCT_ADD: alu_op = ALU_ADD;
         FUNCT_SUB: alu_op = ALU_SUB;
         FUNCT_AND: alu_op = ALU_AND;
         FUNCT_OR:  alu_op = ALU_OR;
         FUNCT_NOR: alu_op = ALU_NOR;
         FUNCT_SLT: alu_op = ALU_SLT;
         FUNCT_SLL: begin
            alu_op   = ALU_SLL;
            is_shift = 1'b1;
         end
         // the ALU right-shifts operand A, so rt must be routed to port A
         FUNCT_SRL: begin
            alu_op       = ALU_SRL;
            is_shift     = 1'b1;
            swap_rt_to_a = 1'b1;
         end
         FUNCT_SRA: begin
            alu_op       = ALU_SRA;
            is_shift     = 1'b1;
            swap_rt_to_a = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/rtype_exec_sequencer.sv
// Multi-cycle R-type initiator driving register-file reads, the ALU and a single
// write-back. Define RTYPE_SEQ_R0_PROTECT_EN to suppress writes to register 0.
//
// state    | meaning
// ST_IDLE  | ready for an instruction
// ST_READ  | read addresses driven, rd1/rd2 captured at cycle end
// ST_EXEC  | operands to ALU, alu_result captured at cycle end
// ST_WB    | write-back pulse, done
// ST_FAULT | illegal instruction, done with err
module rtype_exec_sequencer
   import rtype_exec_sequencer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   output logic [ADDR_W-1:0] rr1,
   output logic [ADDR_W-1:0] rr2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   output logic [4:0]        alu_shamt,
   input  logic [DATA_W-1:0] alu_result,
   output logic [ADDR_W-1:0] wr,
   output logic [DATA_W-1:0] wd,
   output logic              we,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] result
);

   state_t              state_q, state_d;
   logic                instr_ready_q, instr_ready_d;
   logic                we_q, we_d, done_q, done_d, err_q, err_d;
   logic [ADDR_W-1:0]   rr1_q, rr1_d, rr2_q, rr2_d, wr_q, wr_d;
   logic [3:0]          alu_op_q, alu_op_d;
   logic [4:0]          alu_shamt_q, alu_shamt_d;
   logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, result_q, result_d;

   logic [3:0]          dec_op;
   logic                dec_legal, dec_swap, dec_shift;

   rtype_decoder u_dec (
      .opcode       (instr[OPC_MSB:OPC_LSB]),
      .funct        (instr[FUNCT_MSB:FUNCT_LSB]),
      .alu_op       (dec_op),
      .legal        (dec_legal),
      .swap_rt_to_a (dec_swap),
      .is_shift     (dec_shift)
   );

   always_comb begin
      state_d       = state_q;
      instr_ready_d = 1'b0;
      we_d          = 1'b0;
      done_d        = 1'b0;
      err_d         = 1'b0;
      rr1_d         = rr1_q;
      rr2_d         = rr2_q;
      wr_d          = wr_q;
      alu_op_d      = alu_op_q;
      alu_shamt_d   = alu_shamt_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      result_d      = result_q;
      case (state_q)
         ST_IDLE: begin
            instr_ready_d = 1'b1;
            if (instr_valid && instr_ready_q) begin
               instr_ready_d = 1'b0;
               rr1_d       = dec_swap ? instr[RT_MSB:RT_LSB] : instr[RS_MSB:RS_LSB];
               rr2_d       = instr[RT_MSB:RT_LSB];
               wr_d        = instr[RD_MSB:RD_LSB];
               alu_op_d    = dec_op;
               alu_shamt_d = dec_shift ? instr[SHAMT_MSB:SHAMT_LSB] : 5'd0;
               if (dec_legal) begin
                  state_d = ST_READ;
               end else begin
                  state_d = ST_FAULT;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
            end
         end
         ST_READ: begin
            alu_a_d = rd1;
            alu_b_d = rd2;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            result_d = alu_result;
            done_d   = 1'b1;
`ifdef RTYPE_SEQ_R0_PROTECT_EN
            we_d     = (wr_q != '0);
`else
            we_d     = 1'b1;
`endif
            state_d  = ST_WB;
         end
         ST_WB, ST_FAULT: begin
            instr_ready_d = 1'b1;
            state_d       = ST_IDLE;
         end
         default: begin
            instr_ready_d = 1'b1;
            state_d       = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         instr_ready_q <= 1'b1;
         we_q          <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         rr1_q         <= '0;
         rr2_q         <= '0;
         wr_q          <= '0;
         alu_op_q      <= '0;
         alu_shamt_q   <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         result_q      <= '0;
      end else begin
         state_q       <= state_d;
         instr_ready_q <= instr_ready_d;
         we_q          <= we_d;
         done_q        <= done_d;
         err_q         <= err_d;
         rr1_q         <= rr1_d;
         rr2_q         <= rr2_d;
         wr_q          <= wr_d;
         alu_op_q      <= alu_op_d;
         alu_shamt_q   <= alu_shamt_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         result_q      <= result_d;
      end
   end

   assign instr_ready = instr_ready_q;
   assign rr1         = rr1_q;
   assign rr2         = rr2_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;
   assign alu_shamt   = alu_shamt_q;
   assign wr          = wr_q;
   assign wd          = result_q;
   assign we          = we_q;
   assign done        = done_q;
   assign err         = err_q;
   assign result      = result_q;

endmodule

// File: tb/tb_rtype_exec_sequencer.sv
// Bench for rtype_exec_sequencer: behavioural register file and ALU around the
// DUT, directed vector table, reset corner case and randomized instructions.
module tb_rtype_exec_sequencer;

`ifdef RTYPE_SEQ_R0_PROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [4:0]  rr1, rr2, wr;
   logic [31:0] rd1, rd2, alu_a, alu_b, alu_result, wd, result;
   logic [3:0]  alu_op;
   logic [4:0]  alu_shamt;
   logic        we, done, err;

   always #5 clk = ~clk;

   rtype_exec_sequencer #(.DATA_W(32), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .wr(wr), .wd(wd), .we(we), .done(done),
      .err(err), .result(result)
   );

   // behavioural register file with bench-side init and poke port
   logic [31:0] rf [32];
   logic        rf_init, poke_en;
   logic [4:0]  poke_addr;
   logic [31:0] poke_val;

   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 32; i++) rf[i] <= i;
      end else if (poke_en) begin
         rf[poke_addr] <= poke_val;
      end else if (we) begin
         rf[wr] <= wd;
      end
   end
   assign rd1 = rf[rr1];
   assign rd2 = rf[rr2];

   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         4'b0010: alu_result = alu_a + alu_b;
         4'b0110: alu_result = alu_a - alu_b;
         4'b0000: alu_result = alu_a & alu_b;
         4'b0001: alu_result = alu_a | alu_b;
         4'b1100: alu_result = ~(alu_a | alu_b);
         4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         4'b1110: alu_result = alu_b << alu_shamt;
         4'b1101: alu_result = alu_a >> alu_shamt;
         4'b1111: alu_result = $unsigned($signed(alu_a) >>> alu_shamt);
         default: alu_result = 32'd0;
      endcase
   end

   // reference model: architectural register contents and R-type semantics
   logic [31:0] mdl [32];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
      end
   endtask

   function automatic bit ref_legal(input logic [31:0] ins);
      logic [5:0] f;
      f = ins[5:0];
      return (ins[31:26] == 6'd0) &&
             (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03});
   endfunction

   function automatic logic [31:0] ref_val(input logic [31:0] ins);
      logic [31:0] a, b;
      logic [4:0]  sh;
      a  = mdl[ins[25:21]];
      b  = mdl[ins[20:16]];
      sh = ins[10:6];
      case (ins[5:0])
         6'h20: return a + b;
         6'h22: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h27: return ~(a | b);
         6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'h00: return b << sh;
         6'h02: return b >> sh;
         6'h03: return $unsigned($signed(b) >>> sh);
         default: return 32'd0;
      endcase
   endfunction

   task automatic poke(input logic [4:0] a, input logic [31:0] v);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = a; poke_val = v;
      @(posedge clk); #1;
      poke_en = 1'b0;
      mdl[a] = v;
   endtask

   // observations of the most recent run_op
   logic [4:0]  o_rr1, o_rr2, o_sh, o_wr;
   logic [3:0]  o_op;
   logic [31:0] o_wd, o_exp;
   logic        o_we, o_err, o_ready, o_hold, o_legal, o_mwe;
   int          o_lat, o_we_cnt, o_done_cnt;

   task automatic run_op(input logic [31:0] ins, input bit busy_valid);
      int k;
      k = 0;
      while (!instr_ready && k < 10) begin @(posedge clk); #1; k++; end
      o_legal = ref_legal(ins);
      o_exp   = ref_val(ins);
      o_mwe   = o_legal && !(PROT && ins[15:11] == 5'd0);
      @(negedge clk);
      instr = ins; instr_valid = 1'b1;
      @(posedge clk); #1;
      if (busy_valid) instr = 32'h0022_1808;
      else begin instr_valid = 1'b0; instr = $urandom; end
      o_rr1 = rr1; o_rr2 = rr2; o_op = alu_op; o_sh = alu_shamt;
      o_lat = -1; o_we_cnt = 0; o_done_cnt = 0; o_hold = 1'b1;
      o_wr = 'x; o_wd = 'x; o_we = 1'bx; o_err = 1'bx;
      for (int j = 0; j < 8; j++) begin
         if (j > 0) begin @(posedge clk); #1; end
         if (we) o_we_cnt++;
         if (rr1 !== o_rr1 || rr2 !== o_rr2 || alu_op !== o_op || alu_shamt !== o_sh)
            o_hold = 1'b0;
         if (done) begin
            o_done_cnt++;
            o_lat = j; o_wr = wr; o_wd = wd; o_we = we; o_err = err;
            instr_valid = 1'b0;
            break;
         end
      end
      instr_valid = 1'b0;
      @(posedge clk); #1;
      o_ready = instr_ready;
      if (we) o_we_cnt++;
      if (done) o_done_cnt++;
      @(posedge clk); #1;
      if (done) o_done_cnt++;
      if (o_mwe) mdl[ins[15:11]] = o_exp;
   endtask

   typedef struct {
      logic [31:0] ins;
      logic        pk;
      logic [4:0]  pa;
      logic [31:0] pv;
      logic [4:0]  rr1, rr2;
      logic [3:0]  op;
      logic [4:0]  sh;
      logic        err, we;
      logic [4:0]  wr;
      logic [31:0] wd;
   } vec_t;

   vec_t tv [12];

   initial begin
      tv[0]  = '{32'h0022_1820, 1'b0, 5'd0, 32'h0,         5'd1, 5'd2,  4'b0010, 5'd0, 1'b0, 1'b1, 5'd3,  32'h0000_0003};
      tv[1]  = '{32'h0060_2822, 1'b1, 5'd3, 32'hFFFF_F830, 5'd3, 5'd0,  4'b0110, 5'd0, 1'b0, 1'b1, 5'd5,  32'hFFFF_F830};
      tv[2]  = '{32'h0002_2083, 1'b1, 5'd2, 32'hFFFF_FFF8, 5'd2, 5'd2,  4'b1111, 5'd2, 1'b0, 1'b1, 5'd4,  32'hFFFF_FFFE};
      tv[3]  = '{32'h0002_2082, 1'b0, 5'd0, 32'h0,         5'd2, 5'd2,  4'b1101, 5'd2, 1'b0, 1'b1, 5'd4,  32'h3FFF_FFFE};
      tv[4]  = '{32'h0022_1808, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0,  4'b0000, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0};
      tv[5]  = '{32'h0822_1820, 1'b0, 5'd0, 32'h0,         5'd0, 5'd0,  4'b0000, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0};
      tv[6]  = '{32'h007F_3024, 1'b0, 5'd0, 32'h0,         5'd3, 5'd31, 4'b0000, 5'd0, 1'b0, 1'b1, 5'd6,  32'h0000_0010};
      tv[7]  = '{32'h0028_3825, 1'b0, 5'd0, 32'h0,         5'd1, 5'd8,  4'b0001, 5'd0, 1'b0, 1'b1, 5'd7,  32'h0000_0009};
      tv[8]  = '{32'h0022_4027, 1'b0, 5'd0, 32'h0,         5'd1, 5'd2,  4'b1100, 5'd0, 1'b0, 1'b1, 5'd8,  32'h0000_0006};
      tv[9]  = '{32'h0041_482A, 1'b0, 5'd0, 32'h0,         5'd2, 5'd1,  4'b0111, 5'd0, 1'b0, 1'b1, 5'd9,  32'h0000_0001};
      tv[10] = '{32'h0009_5100, 1'b0, 5'd0, 32'h0,         5'd0, 5'd9,  4'b1110, 5'd4, 1'b0, 1'b1, 5'd10, 32'h0000_0010};
      tv[11] = '{32'h0022_0020, 1'b1, 5'd2, 32'h0000_0002, 5'd1, 5'd2,  4'b0010, 5'd0, 1'b0, !PROT, 5'd0, 32'h0000_0003};

      rst = 1'b1; instr_valid = 1'b0; instr = 32'h0;
      rf_init = 1'b1; poke_en = 1'b0; poke_addr = 5'd0; poke_val = 32'h0;
      for (int i = 0; i < 32; i++) mdl[i] = i;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs_zero", {31'd0, |{rr1, rr2, alu_a, alu_b, alu_op, alu_shamt, wr, wd, we, done, err, result}}, 32'd0);
      chk("reset_ready", {31'd0, instr_ready}, 32'd1);
      @(negedge clk); rst = 1'b0; rf_init = 1'b0;

      for (int i = 0; i < 12; i++) begin
         if (tv[i].pk) poke(tv[i].pa, tv[i].pv);
         run_op(tv[i].ins, 1'b0);
         chk($sformatf("v%0d_latency", i), o_lat, tv[i].err ? 0 : 2);
         chk($sformatf("v%0d_err", i), {31'd0, o_err}, {31'd0, tv[i].err});
         chk($sformatf("v%0d_we_count", i), o_we_cnt, tv[i].we ? 1 : 0);
         chk($sformatf("v%0d_ready_after", i), {31'd0, o_ready}, 32'd1);
         chk($sformatf("v%0d_done_count", i), o_done_cnt, 1);
         if (!tv[i].err) begin
            chk($sformatf("v%0d_rr1", i), {27'd0, o_rr1}, {27'd0, tv[i].rr1});
            chk($sformatf("v%0d_rr2", i), {27'd0, o_rr2}, {27'd0, tv[i].rr2});
            chk($sformatf("v%0d_alu_op", i), {28'd0, o_op}, {28'd0, tv[i].op});
            chk($sformatf("v%0d_shamt", i), {27'd0, o_sh}, {27'd0, tv[i].sh});
            chk($sformatf("v%0d_wr", i), {27'd0, o_wr}, {27'd0, tv[i].wr});
            chk($sformatf("v%0d_wd", i), o_wd, tv[i].wd);
            chk($sformatf("v%0d_hold", i), {31'd0, o_hold}, 32'd1);
         end
      end

      // reset during EXEC drops the instruction
      @(negedge clk);
      instr = 32'h0022_1820; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("midrst_outs_zero", {31'd0, |{rr1, rr2, alu_a, alu_b, alu_op, alu_shamt, wr, wd, we, done, err, result}}, 32'd0);
      chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
      @(negedge clk); rst = 1'b0;
      begin
         int pulses;
         pulses = 0;
         for (int j = 0; j < 6; j++) begin
            @(posedge clk); #1;
            if (we || done) pulses++;
         end
         chk("midrst_no_pulse", pulses, 0);
      end
      run_op(32'h0022_1820, 1'b0);
      chk("postrst_wd", o_wd, o_exp);
      chk("postrst_latency", o_lat, 2);
      chk("postrst_we_count", o_we_cnt, 1);

      // randomized instructions against the model; some hold valid while busy
      for (int n = 0; n < 60; n++) begin
         logic [31:0] ins;
         logic [5:0]  fl [9];
         logic        expect_swap;
         bit          bv;
         fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h03};
         ins = $urandom;
         ins[31:26] = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
         ins[5:0]   = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : fl[$urandom_range(0, 8)];
         bv = ($urandom_range(0, 1) == 1);
         poke(5'($urandom_range(0, 31)), $urandom);
         expect_swap = (ins[5:0] == 6'h02 || ins[5:0] == 6'h03);
         run_op(ins, bv);
         chk($sformatf("r%0d_latency", n), o_lat, o_legal ? 2 : 0);
         chk($sformatf("r%0d_err", n), {31'd0, o_err}, {31'd0, !o_legal});
         chk($sformatf("r%0d_we_count", n), o_we_cnt, o_mwe ? 1 : 0);
         chk($sformatf("r%0d_done_count", n), o_done_cnt, 1);
         chk($sformatf("r%0d_ready_after", n), {31'd0, o_ready}, 32'd1);
         if (o_legal) begin
            chk($sformatf("r%0d_wd", n), o_wd, o_exp);
            chk($sformatf("r%0d_wr", n), {27'd0, o_wr}, {27'd0, ins[15:11]});
            chk($sformatf("r%0d_rr1", n), {27'd0, o_rr1}, {27'd0, expect_swap ? ins[20:16] : ins[25:21]});
            chk($sformatf("r%0d_shamt", n), {27'd0, o_sh},
                {27'd0, (ins[5:0] inside {6'h00, 6'h02, 6'h03}) ? ins[10:6] : 5'd0});
            chk($sformatf("r%0d_hold", n), {31'd0, o_hold}, 32'd1);
         end
      end

      for (int i = 0; i < 32; i++) chk($sformatf("rf_final_%0d", i), rf[i], mdl[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rtype_exec_sequencer.md
# rtype_exec_sequencer

- Multi-cycle initiator for the datapath's register-file and ALU ports.
- Accepts one MIPS R-type instruction word per valid/ready handshake and decodes rs/rt/rd/shamt/funct.
- Drives the register-file read addresses, sequences the combinational ALU, then issues a single-cycle register-file write.
- Sits between instruction fetch and the existing register file / ALU / mux datapath, replacing bench-driven RR1/RR2/WR/WE/op stimulus.

## Interface
- DATA_W, 32, datapath width
- ADDR_W, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word offered
- instr_ready  out  1  sequencer idle, can accept
- instr  in  32  R-type instruction word
- rr1, rr2  out  ADDR_W  register-file read addresses
- rd1, rd2  in  DATA_W  register-file read data (combinational from rr1/rr2)
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_op  out  4  ALU opcode
- alu_shamt  out  5  ALU shift count
- alu_result  in  DATA_W  ALU result (combinational)
- wr  out  ADDR_W  write address
- wd  out  DATA_W  write data
- we  out  1  write enable, one-cycle pulse
- done  out  1  one-cycle completion pulse
- err  out  1  valid only with done; illegal instruction
- result  out  DATA_W  last captured ALU result

## Operation
- **States:** IDLE, READ, EXEC, WB, FAULT.
- **Accept:** an instruction is accepted on a clk edge with instr_valid && instr_ready, and is latched. instr_ready=1 only in IDLE.
- **Legality:** the instruction is legal if opcode [31:26]==0 and funct is in the map below. Accept goes to READ if legal, FAULT otherwise.
- **Funct to alu_op map:**
  - add 0x20→0010
  - sub 0x22→0110
  - and 0x24→0000
  - or 0x25→0001
  - nor 0x27→1100
  - slt 0x2A→0111
  - sll 0x00→1110
  - srl 0x02→1101
  - sra 0x03→1111
- **Read addresses:**
  - Default: rr1=rs, rr2=rt.
  - srl/sra: rr1=rt (the ALU shifts A).
  - sll: rr2=rt (the ALU shifts B).
  - alu_shamt=shamt for shift ops, 0 otherwise.
- **READ:** rr1/rr2 are driven. rd1/rd2 are captured into operand registers at the end of READ.
- **EXEC:** alu_a/alu_b/alu_op are driven from the latched operands. alu_result is captured into result at the end of EXEC.
- **WB:** we=1, wr=rd, wd=result, done=1, err=0. WB → IDLE.
- **FAULT:** done=1, err=1, we=0. FAULT → IDLE.
- **Held outputs:** rr1, rr2, alu_op and alu_shamt hold their values from accept until the next accept.
- **Reset:** all outputs are 0 except instr_ready, which is 1. State=IDLE.
- **Reset mid-operation:** the in-flight instruction is dropped with no write and no done.
- **Arithmetic:** all width-exact DATA_W; no overflow detection. rd==rs or rd==rt needs no special handling: the write lands after operand capture.

## Timing
- Legal instruction: accept edge E0; READ cycle; EXEC cycle; WB cycle (we, done high). The register-file write commits at edge E3.
- instr_ready returns to 1 in the cycle after WB. Throughput is one instruction per 4 cycles.
- Illegal instruction: done/err are high in the single cycle after accept. instr_ready is 1 again the cycle after that.
- instr_valid while busy is ignored. The source must hold instr stable until accepted.

## Configuration
- Macro: RTYPE_SEQ_R0_PROTECT_EN.
- Defined: when rd==0, the WB cycle keeps we=0 and done=1 still pulses.
- Undefined: a write to register 0 is issued like any other, matching the current register file, which permits r0 writes.

## Structure
- A shared package holds:
  - the funct constants;
  - the 4-bit ALU opcode constants (0010, 0110, 0000, 0001, 1100, 0111, 1110, 1101, 1111);
  - the state enum;
  - the instruction field bit positions.
- One sub-module, rtype_decoder: a combinational funct/opcode → {alu_op, legal, swap_rt_to_a, is_shift} decoder. The FSM and output registers stay in the top.

## Test plan
The bench uses a behavioural register file with reg[i]=i at start, plus a behavioural ALU.
- add $3,$1,$2 (0x00221820) accepted at E0:
  - rr1=1, rr2=2;
  - we=1, wr=3, wd=3, done=1 in cycle E0+3;
  - instr_ready=1 at E0+4.
- reg3=-2000, then sub $5,$3,$0: wd=-2000 (0xFFFFF830), wr=5.
- reg2=-8:
  - sra $4,$2,2 (0x00022083): rr1=2, alu_shamt=2, wd=0xFFFFFFFE;
  - srl with the same fields: wd=0x3FFFFFFE.
- funct 0x08: done=1, err=1 one cycle after accept; we never asserted.
- rst asserted during EXEC of an add:
  - all outputs go to 0 immediately, with instr_ready=1;
  - no we pulse follows;
  - the next add completes normally.
- add $0,$1,$2:
  - with RTYPE_SEQ_R0_PROTECT_EN: done=1, we=0;
  - without it: we=1, wr=0, wd=3.
